// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package inst_fetch_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] inst_data_t;

  localparam logic       CHIP_ENABLE      = 1'b1;
  localparam logic       CHIP_DISABLE     = 1'b0;
  localparam addr_t      RESET_PC_DEFAULT = 32'h0000_0000;
  localparam inst_data_t INST_NOP         = 32'h0000_0000;

endpackage

// File: rtl/i_instbus.sv
// Instruction ROM bus: fetch stage drives enable/address, ROM returns data combinationally.
interface i_instbus #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              ce;
  logic [ADDR_W-1:0] addr;
  logic [INST_W-1:0] data;

  modport master (output ce, output addr, input data);
  modport slave  (input ce, input addr, output data);
endinterface

// File: rtl/inst_fetch_pc_reg.sv
// Program counter, fetch enable and the branch target parked while the pipe is stalled.
module inst_fetch_pc_reg
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              ce_r
);

  logic              pend_valid;
  logic [ADDR_W-1:0] pend_target;
  logic [ADDR_W-1:0] flush_aligned;
  logic [ADDR_W-1:0] branch_aligned;

  assign flush_aligned  = {flush_pc[ADDR_W-1:2], 2'b00};
  assign branch_aligned = {branch_target[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_r        <= CHIP_DISABLE;
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      ce_r <= CHIP_ENABLE;
      // The PC only advances once the ROM has been enabled for a cycle.
      if (ce_r == CHIP_ENABLE) begin
        if (flush) begin
          pc         <= flush_aligned;
          pend_valid <= 1'b0;
        end else if (stall) begin
          if (branch_valid) begin
            pend_valid  <= 1'b1;
            pend_target <= branch_aligned;
          end
        end else if (pend_valid) begin
          pc         <= pend_target;
          pend_valid <= 1'b0;
        end else if (branch_valid) begin
          pc <= branch_aligned;
        end else begin
          pc <= pc + ADDR_W'(4);
        end
      end
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: drives the ROM from the PC and captures the IF/ID pipeline register.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  i_instbus.master          rom,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid
);

  logic [ADDR_W-1:0] pc;
  logic              ce_r;

  inst_fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .pc            (pc),
    .ce_r          (ce_r)
  );

  assign rom.ce   = ce_r;
  assign rom.addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_pc    <= '0;
      id_inst  <= INST_W'(INST_NOP);
      id_valid <= 1'b0;
    end else if (flush) begin
      id_pc    <= '0;
      id_inst  <= INST_W'(INST_NOP);
      id_valid <= 1'b0;
    end else if (!stall) begin
      // Nothing real is fetched while the ROM is still disabled.
      id_pc    <= pc;
      id_inst  <= (ce_r == CHIP_ENABLE) ? rom.data : INST_W'(INST_NOP);
      id_valid <= (ce_r == CHIP_ENABLE);
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch; the ROM returns {8'hA5, addr[23:0]} for each address.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  int checks = 0;
  int errors = 0;

  i_instbus #(.ADDR_W(32), .INST_W(32)) rom_bus ();
  assign rom_bus.data = {8'hA5, rom_bus.addr[23:0]};

  inst_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rom           (rom_bus),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_valid      (id_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = '0;
    branch_valid = 1'b0; branch_target = '0;
    @(negedge clk);
    check("rst_ce", {31'b0, rom_bus.ce}, 32'h0);
    check("rst_addr", rom_bus.addr, 32'h0);
    check("rst_id_valid", {31'b0, id_valid}, 32'h0);
    check("rst_id_inst", id_inst, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    rst_n = 1'b1;

    // Enable cycle, then sequential fetch
    step();
    check("en_ce", {31'b0, rom_bus.ce}, 32'h1);
    check("en_addr", rom_bus.addr, 32'h0);
    check("en_id_valid", {31'b0, id_valid}, 32'h0);
    step();
    check("seq_addr4", rom_bus.addr, 32'h4);
    check("seq_inst0", id_inst, 32'hA500_0000);
    check("seq_valid0", {31'b0, id_valid}, 32'h1);
    step();
    check("seq_addr8", rom_bus.addr, 32'h8);
    check("seq_inst1", id_inst, 32'hA500_0004);

    // Branch at pc=8; delay slot still reaches ID
    branch_valid = 1'b1; branch_target = 32'h40;
    step();
    branch_valid = 1'b0;
    check("br_addr", rom_bus.addr, 32'h40);
    check("br_slot_pc", id_pc, 32'h8);
    check("br_slot_inst", id_inst, 32'hA500_0008);
    check("br_slot_valid", {31'b0, id_valid}, 32'h1);
    step();
    check("br_next_addr", rom_bus.addr, 32'h44);
    check("br_next_id_pc", id_pc, 32'h40);

    // Redirect to 8, advance to C, then stall 3 cycles with a branch pulse
    flush = 1'b1; flush_pc = 32'h8;
    step();
    flush = 1'b0;
    check("fl8_addr", rom_bus.addr, 32'h8);
    check("fl8_id_valid", {31'b0, id_valid}, 32'h0);
    step();
    check("preStall_addr", rom_bus.addr, 32'hC);
    stall = 1'b1; branch_valid = 1'b1; branch_target = 32'h80;
    step();
    branch_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_addr", rom_bus.addr, 32'hC);
      check("stall_id_pc", id_pc, 32'h8);
      check("stall_id_inst", id_inst, 32'hA500_0008);
      if (i < 2) step();
    end
    stall = 1'b0;
    step();
    check("pend_addr", rom_bus.addr, 32'h80);
    check("pend_id_pc", id_pc, 32'hC);
    check("pend_id_inst", id_inst, 32'hA500_000C);
    step();
    check("pend_after", rom_bus.addr, 32'h84);

    // Flush beats stall, branch and an existing pending branch
    stall = 1'b1; branch_valid = 1'b1; branch_target = 32'h200;
    step();
    flush = 1'b1; flush_pc = 32'h180; branch_target = 32'h300;
    step();
    flush = 1'b0; stall = 1'b0; branch_valid = 1'b0;
    check("fl_addr", rom_bus.addr, 32'h180);
    check("fl_id_valid", {31'b0, id_valid}, 32'h0);
    check("fl_id_inst", id_inst, 32'h0);
    check("fl_id_pc", id_pc, 32'h0);
    step();
    check("fl_pend_clr", rom_bus.addr, 32'h184);
    check("fl_next_id_pc", id_pc, 32'h180);
    check("fl_next_inst", id_inst, 32'hA500_0180);

    // Wrap and misaligned branch target
    flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
    step();
    flush = 1'b0;
    check("wrap_top", rom_bus.addr, 32'hFFFF_FFFC);
    step();
    check("wrap_addr", rom_bus.addr, 32'h0);
    check("wrap_id_inst", id_inst, 32'hA5FF_FFFC);
    branch_valid = 1'b1; branch_target = 32'h43;
    step();
    branch_valid = 1'b0;
    check("align_addr", rom_bus.addr, 32'h40);

    // Misaligned flush target
    flush = 1'b1; flush_pc = 32'h0000_0127;
    step();
    flush = 1'b0;
    check("fl_align", rom_bus.addr, 32'h124);

    // Pending branch wins over a new unstalled branch
    stall = 1'b1; branch_valid = 1'b1; branch_target = 32'h100;
    step();
    stall = 1'b0; branch_target = 32'h200;
    step();
    branch_valid = 1'b0;
    check("pend_wins", rom_bus.addr, 32'h100);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ce", {31'b0, rom_bus.ce}, 32'h0);
    check("mid_rst_addr", rom_bus.addr, 32'h0);
    check("mid_rst_valid", {31'b0, id_valid}, 32'h0);
    check("mid_rst_id_pc", id_pc, 32'h0);
    check("mid_rst_inst", id_inst, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("re_ce", {31'b0, rom_bus.ce}, 32'h1);
    check("re_addr", rom_bus.addr, 32'h0);
    check("re_valid", {31'b0, id_valid}, 32'h0);
    step();
    check("re_addr4", rom_bus.addr, 32'h4);
    check("re_inst0", id_inst, 32'hA500_0000);
    check("re_valid1", {31'b0, id_valid}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM chip-enable and address over the i_instbus master modport.
- Captures the returned instruction word into the IF/ID pipeline register for the decode stage.
- Handles pipeline stall, flush/exception redirect and branch redirect, including branches that arrive while the pipe is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC value fetched first after reset.
- ADDR_W, 32, PC/address width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- rom (i_instbus.master), ce  out  1  ROM chip enable: CHIP_ENABLE / CHIP_DISABLE.
- rom (i_instbus.master), addr  out  ADDR_W  byte address of the current fetch.
- rom (i_instbus.master), data  in  INST_W  combinational instruction returned by the ROM.
- stall  in  1  hold the PC and IF/ID contents.
- flush  in  1  discard IF/ID contents and redirect to flush_pc.
- flush_pc  in  ADDR_W  redirect target for flush (exception/eret).
- branch_valid  in  1  taken branch/jump resolved in ID.
- branch_target  in  ADDR_W  branch destination.
- id_pc  out  ADDR_W  PC of the instruction held in IF/ID.
- id_inst  out  INST_W  instruction held in IF/ID.
- id_valid  out  1  IF/ID holds a real fetched instruction.

Behaviour:
Reset (async assert while rst_n=0):
- ce_r=CHIP_DISABLE, pc=RESET_PC.
- pend_valid=0, pend_target=0.
- id_pc=0, id_inst=0 (NOP), id_valid=0.

Fetch enable:
- ce_r becomes CHIP_ENABLE on the first rising edge after rst_n deasserts, then stays enabled.
- rom.ce=ce_r; rom.addr=pc (combinational from the register).
- While ce_r=CHIP_DISABLE, pc is held at RESET_PC. The first fetched address is therefore RESET_PC.

Next-PC priority, evaluated each edge while ce_r is enabled:
1. flush: pc<=flush_pc; pend_valid<=0.
2. stall: pc holds. If branch_valid, pend_valid<=1 and pend_target<=branch_target (latest wins).
3. pend_valid: pc<=pend_target; pend_valid<=0.
4. branch_valid: pc<=branch_target.
5. Otherwise pc<=pc+4, modulo 2^ADDR_W (32'hFFFF_FFFC wraps to 0).

PC rules:
- Bits [1:0] of every loaded PC are forced to 00; misaligned target bits are dropped.
- Branch delay slot is implicit: the instruction already fetched when branch_valid arrives is passed to ID normally and is not squashed.

IF/ID register:
- flush: id_inst<=0, id_valid<=0, id_pc<=0.
- else stall: hold all three.
- else: id_pc<=pc, id_inst<=rom.data, id_valid<=(ce_r==CHIP_ENABLE). When disabled, id_inst<=0.

Simultaneous events:
- flush+stall: flush wins.
- flush+branch_valid: flush wins and the branch is dropped.
- pending branch present and a new branch_valid with stall=0: the pending branch wins and the new one is ignored.

Reset mid-operation:
- All state returns to reset values immediately. Fetch restarts from RESET_PC after the enable cycle.

Latency:
- Instruction at address A is visible on id_inst one edge after pc=A, absent stall.

Decomposition:
- project_types additions: addr_t, inst_data_t (existing), CHIP_ENABLE/CHIP_DISABLE (existing), RESET_PC constant, INST_NOP=32'h0.
- One natural sub-module, pc_reg: owns ce_r, pc and the pending-branch registers, and exposes pc/ce.
- The IF/ID register stays in inst_fetch.

Test Plan:
- Reset release, no stall: rom.ce=0 in cycle 0, then 1. rom.addr sequence 0,4,8,C. id_inst equals ROM words 0..3, id_valid=1 from the second enabled edge.
- branch_valid with branch_target=32'h40 while pc=8: pc sequence 8→40. Instruction at 8 (delay slot) still reaches ID with id_valid=1.
- stall high for 3 cycles at pc=C: rom.addr stays C and id_pc/id_inst hold. branch_valid pulse to 32'h80 during the stall: pc=80 on the first edge after stall drops.
- flush with flush_pc=32'h180, with stall and branch_valid asserted in the same cycle: next pc=180, id_valid=0, id_inst=0, pending branch cleared.
- Wrap: force pc to 32'hFFFF_FFFC, no events → next rom.addr=0. branch_target=32'h43 → pc=40.
- Assert rst_n=0 mid-run at pc=100 (asynchronous, between edges): outputs reset immediately. After release, fetch resumes at RESET_PC after one disabled cycle.
